// File: rtl/test_fifo_sc.sv
// Single-clock width-converting FIFO: packs DIN_W beats MSB-first into DOUT_W words
// and stores them in a simple dual-port RAM with a registered read port.
module test_fifo_sc #(
  parameter int unsigned DIN_W       = 16,
  parameter int unsigned DOUT_W      = 128,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic              refclk,
  input  logic              reset_n,
  input  logic [DIN_W-1:0]  din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DOUT_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned RATIO  = DOUT_W / DIN_W;
  localparam int unsigned BEAT_W = $clog2(RATIO);
  localparam int unsigned PTR_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ASM_W  = DOUT_W - DIN_W;

  logic [DOUT_W-1:0] mem [DEPTH_WORDS];

  logic [ASM_W-1:0]  asm_q,    asm_d;
  logic [BEAT_W-1:0] beat_q,   beat_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              empty_q,  empty_d;
  logic              full_q,   full_d;
  logic              ovf_q,    ovf_d;
  logic              unf_q,    unf_d;
  logic [DOUT_W-1:0] dout_q;

  logic              wr_acc_c;
  logic              rd_acc_c;
  logic              commit_c;
  logic [DOUT_W-1:0] word_c;

  // Packing, pointer, count and flag next-state
  always_comb begin
    wr_acc_c = wr_en && !full_q;
    rd_acc_c = rd_en && !empty_q;
    commit_c = wr_acc_c && (beat_q == BEAT_W'(RATIO - 1));
    word_c   = {asm_q, din};

    asm_d    = asm_q;
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc_c) begin
      asm_d  = word_c[ASM_W-1:0];
      beat_d = commit_c ? '0 : beat_q + BEAT_W'(1);
    end
    if (commit_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(commit_c) - CNT_W'(rd_acc_c);

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH_WORDS));
    ovf_d   = wr_en && full_q;
    unf_d   = rd_en && empty_q;
  end

  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      asm_q    <= '0;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      asm_q    <= asm_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // RAM write port: the completed word goes in on the edge of its last beat
  always_ff @(posedge refclk) begin
    if (reset_n && commit_c) begin
      mem[wr_ptr_q] <= word_c;
    end
  end

  // RAM registered read port; holds until the next successful pop
  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else if (rd_acc_c) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

  assign dout      = dout_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_test_fifo_sc.sv
// Bench for test_fifo_sc: directed and random scenarios checked against a
// queue-based model of beats, words and flag pulses.
module tb_test_fifo_sc;

  logic         refclk;
  logic         reset_n;
  logic [15:0]  din;
  logic         wr_en;
  logic         rd_en;
  logic [127:0] dout;
  logic         empty;
  logic         full;
  logic         overflow;
  logic         underflow;

  int checks;
  int failures;

  // Reference model state
  logic [127:0] mq[$];
  logic [15:0]  mpart[$];
  logic [127:0] m_dout;
  logic         m_ovf;
  logic         m_unf;
  int           m_words;

  test_fifo_sc dut (
    .refclk    (refclk),
    .reset_n   (reset_n),
    .din       (din),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after it
  task automatic cycle(input logic rn, input logic w, input logic [15:0] d, input logic r);
    bit full_pre, empty_pre;
    logic [127:0] wd;
    reset_n = rn; wr_en = w; din = d; rd_en = r;
    @(posedge refclk);
    full_pre  = (mq.size() == 64);
    empty_pre = (mq.size() == 0);
    if (!rn) begin
      mq.delete(); mpart.delete();
      m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_ovf = w && full_pre;
      m_unf = r && empty_pre;
      if (r && !empty_pre) m_dout = mq.pop_front();
      if (w && !full_pre) begin
        mpart.push_back(d);
        if (mpart.size() == 8) begin
          wd = '0;
          for (int i = 0; i < 8; i++) wd = {wd[111:0], mpart[i]};
          mq.push_back(wd);
          mpart.delete();
          m_words++;
        end
      end
    end
    #1;
    reset_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (dout !== 128'h0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: dout=%h empty=%b full=%b ovf=%b unf=%b, want 0/1/0/0/0",
               dout, empty, full, overflow, underflow);
    end
  endtask

  task automatic test_pack();
    logic [127:0] want;
    want = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, 16'(i), 1'b0);
      checks++;
      if (empty !== (i < 8)) begin
        failures++;
        $display("FAIL pack_empty beat %0d: empty=%b want %b", i, empty, (i < 8));
      end
    end
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    checks++;
    if (dout !== want || empty !== 1'b1) begin
      failures++;
      $display("FAIL pack_dout: dout=%h empty=%b want %h 1", dout, empty, want);
    end
  endtask

  task automatic test_partial_underflow();
    logic [127:0] held;
    held = m_dout;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
      checks++;
      if (empty !== 1'b1) begin
        failures++;
        $display("FAIL partial_empty beat %0d: empty=%b want 1", i, empty);
      end
    end
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    checks++;
    if (underflow !== 1'b1 || dout !== held) begin
      failures++;
      $display("FAIL underflow_pulse: unf=%b dout=%h want 1 %h", underflow, dout, held);
    end
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (underflow !== 1'b0 || dout !== held) begin
      failures++;
      $display("FAIL underflow_clear: unf=%b dout=%h want 0 %h", underflow, dout, held);
    end
  endtask

  task automatic test_full();
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 64 * 8; i++) begin
      cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
      if (i == 64 * 8 - 2) begin
        checks++;
        if (full !== 1'b0) begin
          failures++;
          $display("FAIL full_early: full=%b want 0", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL full_set: full=%b empty=%b want 1 0", full, empty);
    end
    cycle(1'b1, 1'b1, 16'hdead, 1'b0);
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      failures++;
      $display("FAIL overflow_pulse: ovf=%b full=%b want 1 1", overflow, full);
    end
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear: ovf=%b want 0", overflow);
    end
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      checks++;
      if (dout !== m_dout || full !== (mq.size() == 64) || empty !== (mq.size() == 0)) begin
        failures++;
        $display("FAIL full_readback word %0d: dout=%h full=%b empty=%b want %h %b %b",
                 i, dout, full, empty, m_dout, (mq.size() == 64), (mq.size() == 0));
      end
    end
  endtask

  task automatic test_same_cycle();
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 16'($urandom), 1'b1);
    checks++;
    if (empty !== 1'b0 || dout !== m_dout || mq.size() != 1) begin
      failures++;
      $display("FAIL same_cycle_commit_pop: empty=%b dout=%h want 0 %h (model words %0d)",
               empty, dout, m_dout, mq.size());
    end
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    checks++;
    if (empty !== 1'b1 || dout !== m_dout) begin
      failures++;
      $display("FAIL same_cycle_second: empty=%b dout=%h want 1 %h", empty, dout, m_dout);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (empty !== 1'b1 || dout !== 128'h0) begin
      failures++;
      $display("FAIL reset_mid: empty=%b dout=%h want 1 0", empty, dout);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'(16'ha000 + i), 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    checks++;
    if (dout !== 128'ha000_a001_a002_a003_a004_a005_a006_a007 || empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_fresh_word: dout=%h empty=%b want a000..a007 1", dout, empty);
    end
  endtask

  task automatic test_wrap();
    int start;
    int n;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    start = m_words;
    n = 0;
    while (m_words - start < 74 && n < 4000) begin
      cycle(1'b1, ($urandom % 4) != 0, 16'($urandom), ($urandom % 10) == 0);
      n++;
      checks++;
      if (dout !== m_dout || empty !== (mq.size() == 0) || full !== (mq.size() == 64) ||
          overflow !== m_ovf || underflow !== m_unf) begin
        failures++;
        $display("FAIL wrap_step %0d: dout=%h e=%b f=%b o=%b u=%b want %h %b %b %b %b",
                 n, dout, empty, full, overflow, underflow, m_dout,
                 (mq.size() == 0), (mq.size() == 64), m_ovf, m_unf);
      end
    end
    checks++;
    if (m_words - start < 74) begin
      failures++;
      $display("FAIL wrap_budget: words=%0d want 74", m_words - start);
    end
    n = 0;
    while (mq.size() > 0 && n < 200) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      n++;
      checks++;
      if (dout !== m_dout) begin
        failures++;
        $display("FAIL wrap_drain %0d: dout=%h want %h", n, dout, m_dout);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_empty: empty=%b want 1", empty);
    end
  endtask

  initial begin
    checks = 0; failures = 0; m_words = 0;
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    test_reset();
    test_pack();
    test_partial_underflow();
    test_full();
    test_same_cycle();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
